// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master round-robin bus arbiter with hold timeout
// Grants are held until done or withdrawal; a hung owner is force-released after TIMEOUT cycles.
module bus_arbiter_2m #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   input  logic done,
   output logic grant1,
   output logic grant2,
   output logic master_sel,
   output logic busy,
   output logic timeout_err,
   output logic err_master
);

   typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             rel;
   logic             tmo;

   // last: 0 = master1 served last, 1 = master2 served last
   function automatic state_t arb(input logic r1, input logic r2, input logic l);
      if (r1 && r2)
         return l ? GNT1 : GNT2;
      else if (r1)
         return GNT1;
      else if (r2)
         return GNT2;
      else
         return IDLE;
   endfunction

   always_comb begin
      nxt = state;
      rel = 1'b0;
      tmo = 1'b0;
      case (state)
         IDLE: nxt = arb(req1, req2, last);
         GNT1: begin
            if (done || !req1) begin
               rel = 1'b1;
               nxt = arb(req1, req2, 1'b0);
            end else if (cnt == CNT_MAX) begin
               rel = 1'b1;
               tmo = 1'b1;
               nxt = arb(1'b0, req2, 1'b0);
            end
         end
         GNT2: begin
            if (done || !req2) begin
               rel = 1'b1;
               nxt = arb(req1, req2, 1'b1);
            end else if (cnt == CNT_MAX) begin
               rel = 1'b1;
               tmo = 1'b1;
               nxt = arb(req1, 1'b0, 1'b1);
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant1      <= 1'b0;
         grant2      <= 1'b0;
         master_sel  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         err_master  <= 1'b0;
         cnt         <= '0;
         last        <= 1'b1;
      end else begin
         state       <= nxt;
         grant1      <= (nxt == GNT1);
         grant2      <= (nxt == GNT2);
         busy        <= (nxt != IDLE);
         timeout_err <= tmo;
         // mux select only moves with a grant so it never glitches through IDLE
         if (nxt == GNT1)
            master_sel <= 1'b0;
         else if (nxt == GNT2)
            master_sel <= 1'b1;
         if (tmo)
            err_master <= (state == GNT2);
         if (rel)
            last <= (state == GNT2);
         if (rel || nxt != state)
            cnt <= '0;
         else if (state != IDLE)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - scoreboard testbench for bus_arbiter_2m
// Expected {grant1,grant2,master_sel,busy,timeout_err,err_master} is queued per driven cycle.
module tb_bus_arbiter_2m;

   typedef struct {
      int          cyc;
      logic [5:0]  exp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req1 = 1'b0;
   logic req2 = 1'b0;
   logic done = 1'b0;
   logic grant1, grant2, master_sel, busy, timeout_err, err_master;

   exp_t q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   bus_arbiter_2m #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .req1        (req1),
      .req2        (req2),
      .done        (done),
      .grant1      (grant1),
      .grant2      (grant2),
      .master_sel  (master_sel),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_master  (err_master)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic r1, input logic r2, input logic d,
                       input logic [5:0] e, input string nm);
      exp_t x;
      @(negedge clk);
      rst  = r;
      req1 = r1;
      req2 = r2;
      done = d;
      x.cyc  = cyc + 1;
      x.exp  = e;
      x.name = nm;
      q.push_back(x);
   endtask

   // monitor: compare queued expectations against outputs after each edge
   initial begin
      logic [5:0] act;
      exp_t       x;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         act = {grant1, grant2, master_sel, busy, timeout_err, err_master};
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            n_checks++;
            if (x.cyc != cyc || act !== x.exp) begin
               n_fail++;
               $display("FAIL %s cyc=%0d: got g1g2 sel busy terr em=%b, want %b (due cyc %0d)",
                        x.name, cyc, act, x.exp, x.cyc);
            end
         end
         if (cyc >= 2) begin
            n_checks++;
            if ((grant1 && grant2) || (busy !== (grant1 | grant2)) ||
                (grant1 && master_sel) || (grant2 && !master_sel)) begin
               n_fail++;
               $display("FAIL invariant cyc=%0d: got g1=%b g2=%b sel=%b busy=%b, want exclusive grants, sel=owner, busy=g1|g2",
                        cyc, grant1, grant2, master_sel, busy);
            end
         end
      end
   end

   initial begin
      // reset held two cycles with a pending request, then grant one cycle later
      step(1, 1, 0, 0, 6'b000000, "t1_reset_a");
      step(1, 1, 0, 0, 6'b000000, "t1_reset_b");
      step(0, 1, 0, 0, 6'b100100, "t1_first_grant");
      step(0, 1, 0, 1, 6'b100100, "t1_regrant_same");
      step(0, 0, 0, 0, 6'b000000, "t1_withdraw_idle");

      // alternation with no idle gap
      step(1, 0, 0, 0, 6'b000000, "t2_reset");
      step(0, 1, 1, 0, 6'b100100, "t2_tie_m1");
      step(0, 1, 1, 1, 6'b011100, "t2_done_to_m2");
      step(0, 1, 1, 1, 6'b100100, "t2_done_to_m1");
      step(0, 1, 1, 1, 6'b011100, "t2_done_to_m2b");

      // master2 hangs with nobody else waiting
      for (int i = 0; i < 15; i++)
         step(0, 0, 1, 0, 6'b011100, "t3_hold_m2");
      step(0, 0, 1, 0, 6'b001011, "t3_timeout_m2");
      step(0, 0, 0, 0, 6'b001001, "t3_pulse_end");

      // master1 hangs while master2 waits: release hands bus to master2
      step(0, 1, 0, 0, 6'b100101, "t3_grant_m1");
      for (int i = 0; i < 15; i++)
         step(0, 1, 0, 0, 6'b100101, "t3_hold_m1");
      step(0, 1, 1, 0, 6'b011110, "t3_timeout_m1");
      step(0, 0, 1, 1, 6'b011100, "t3_regrant_m2");

      // done on the timeout cycle wins
      for (int i = 0; i < 15; i++)
         step(0, 0, 1, 0, 6'b011100, "t4_hold_m2");
      step(0, 1, 1, 1, 6'b100100, "t4_done_beats_timeout");

      // withdrawal hands over directly
      step(0, 0, 1, 0, 6'b011100, "t5_withdraw_to_m2");

      // reset mid-grant
      step(0, 0, 1, 0, 6'b011100, "t6_hold_m2");
      step(1, 1, 1, 0, 6'b000000, "t6_reset_mid_grant");
      step(0, 1, 1, 0, 6'b100100, "t6_tie_after_reset");
      step(0, 0, 0, 1, 6'b000000, "t6_release_idle");

      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
